// File: rtl/bcd_time_loader_pkg.sv
// Shared state encoding and range limits for BCD time entry.
// No logic: consumed by the loader top and its bench.
package bcd_time_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HR_T,
    HR_U,
    SEC_T,
    SEC_U,
    LOAD
  } state_e;

  localparam int MAX_HR_24 = 23;
  localparam int MAX_HR_12 = 12;
  localparam int MAX_SEC   = 59;
  localparam int BCD_MAX   = 9;

endpackage

// File: rtl/bcd_time_loader_if.sv
// Preset channel from the loader to the time counters.
// Valid/ready: the master holds load_valid and data until load_ready is seen.
interface bcd_time_loader_if #(
  parameter int WIDTH_HR  = 5,
  parameter int WIDTH_SEC = 6
);

  logic                 load_valid;
  logic                 load_ready;
  logic [WIDTH_HR-1:0]  hr_bin;
  logic [WIDTH_SEC-1:0] sec_bin;

  modport master (
    output load_valid,
    output hr_bin,
    output sec_bin,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  hr_bin,
    input  sec_bin,
    output load_ready
  );

endinterface

// File: rtl/bcd_time_loader_entry_timer.sv
// Restartable down-counter: expired_o is high once TIMEOUT_CYC enabled cycles pass since restart.
// Combinational expiry flag, no backpressure.
module bcd_time_loader_entry_timer #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = RELOAD;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Restart priority is resolved by the caller, so expiry is not gated by it.
  assign expired_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/bcd_time_loader.sv
// Collects HH SS BCD digits, range-checks them per 12h/24h mode, emits a binary preset.
// Preset valid one cycle after the last digit; held stable until load_ready.
module bcd_time_loader
  import bcd_time_loader_pkg::*;
#(
  parameter int WIDTH_HR    = 5,
  parameter int WIDTH_SEC   = 6,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cancel,
  input  logic                 mode,
  input  logic                 pm,
  input  logic                 digit_valid,
  input  logic [3:0]           digit,
  bcd_time_loader_if.master    load,
  output logic                 busy,
  output logic [1:0]           digit_pos,
  output logic                 err
);

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [3:0]           hr_t_q, hr_t_d;
  logic [3:0]           hr_u_q, hr_u_d;
  logic [3:0]           sec_t_q, sec_t_d;
  logic [WIDTH_HR-1:0]  hr_q, hr_d;
  logic [WIDTH_SEC-1:0] sec_q, sec_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic       digit_ok;
  logic       restart;
  logic       expired;
  logic [6:0] hr_raw, hr_conv, sec_raw;

  always_comb begin
    digit_ok = 1'b0;
    if (digit <= 4'(BCD_MAX)) begin
      case (state_q)
        HR_T:  digit_ok = mode_q ? (digit <= 4'(MAX_HR_24 / 10))
                                 : (digit <= 4'(MAX_HR_12 / 10));
        HR_U: begin
          if (mode_q) begin
            digit_ok = (hr_t_q == 4'(MAX_HR_24 / 10)) ? (digit <= 4'(MAX_HR_24 % 10)) : 1'b1;
          end else if (hr_t_q == 4'(MAX_HR_12 / 10)) begin
            digit_ok = (digit <= 4'(MAX_HR_12 % 10));
          end else begin
            digit_ok = (digit != 4'd0);
          end
        end
        SEC_T:   digit_ok = (digit <= 4'(MAX_SEC / 10));
        SEC_U:   digit_ok = 1'b1;
        default: digit_ok = 1'b0;
      endcase
    end
  end

  // 12h: hour 12 is midnight/noon, every other hour shifts by 12 in the afternoon.
  always_comb begin
    hr_raw  = 7'(hr_t_q) * 7'd10 + 7'(hr_u_q);
    sec_raw = 7'(sec_t_q) * 7'd10 + 7'(digit);
    hr_conv = hr_raw;
    if (!mode_q) begin
      if (hr_raw == 7'(MAX_HR_12)) begin
        hr_conv = pm ? 7'(MAX_HR_12) : 7'd0;
      end else if (pm) begin
        hr_conv = hr_raw + 7'(MAX_HR_12);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hr_t_d  = hr_t_q;
    hr_u_d  = hr_u_q;
    sec_t_d = sec_t_q;
    hr_d    = hr_q;
    sec_d   = sec_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          state_d = HR_T;
          mode_d  = mode;
          restart = 1'b1;
        end
      end
      LOAD: begin
        if (load.load_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = HR_T;
          mode_d  = mode;
          restart = 1'b1;
        end else if (digit_valid && digit_ok) begin
          restart = 1'b1;
          case (state_q)
            HR_T: begin
              hr_t_d  = digit;
              state_d = HR_U;
            end
            HR_U: begin
              hr_u_d  = digit;
              state_d = SEC_T;
            end
            SEC_T: begin
              sec_t_d = digit;
              state_d = SEC_U;
            end
            default: begin
              hr_d    = WIDTH_HR'(hr_conv);
              sec_d   = WIDTH_SEC'(sec_raw);
              valid_d = 1'b1;
              state_d = LOAD;
            end
          endcase
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (digit_valid) begin
          err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      hr_t_q  <= '0;
      hr_u_q  <= '0;
      sec_t_q <= '0;
      hr_q    <= '0;
      sec_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      hr_t_q  <= hr_t_d;
      hr_u_q  <= hr_u_d;
      sec_t_q <= sec_t_d;
      hr_q    <= hr_d;
      sec_q   <= sec_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  bcd_time_loader_entry_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart),
    .enable_i  (busy),
    .expired_o (expired)
  );

  always_comb begin
    case (state_q)
      HR_U:    digit_pos = 2'd1;
      SEC_T:   digit_pos = 2'd2;
      SEC_U:   digit_pos = 2'd3;
      default: digit_pos = 2'd0;
    endcase
  end

  assign busy            = (state_q == HR_T) || (state_q == HR_U) ||
                           (state_q == SEC_T) || (state_q == SEC_U);
  assign err             = err_q;
  assign load.load_valid = valid_q;
  assign load.hr_bin     = hr_q;
  assign load.sec_bin    = sec_q;

endmodule

// File: tb/tb_bcd_time_loader.sv
// Bench for bcd_time_loader: directed cases with literal expectations, then random traffic
// compared every cycle against a digit-list model of time entry.
module tb_bcd_time_loader;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       mode = 1'b0;
  logic       pm = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       busy;
  logic [1:0] digit_pos;
  logic       err;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bcd_time_loader_if #(.WIDTH_HR(5), .WIDTH_SEC(6)) lif ();

  bcd_time_loader #(
    .WIDTH_HR    (5),
    .WIDTH_SEC   (6),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cancel      (cancel),
    .mode        (mode),
    .pm          (pm),
    .digit_valid (digit_valid),
    .digit       (digit),
    .load        (lif.master),
    .busy        (busy),
    .digit_pos   (digit_pos),
    .err         (err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // A digit is legal when some valid time still begins with the digits entered so far.
  function automatic bit acceptable(input int n, input int d, input bit md, input int t0, input int t2);
    int hmax;
    int hmin;
    hmax = md ? 23 : 12;
    hmin = md ? 0 : 1;
    if (d > 9) return 1'b0;
    case (n)
      0:       return (d * 10) <= hmax;
      1:       return ((t0 * 10 + d) <= hmax) && ((t0 * 10 + d) >= hmin);
      2:       return (d * 10) <= 59;
      default: return (t2 * 10 + d) <= 59;
    endcase
  endfunction

  bit m_active, m_load, m_err, m_mode;
  int m_n, m_since, m_hr, m_sec;
  int m_dig [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_load   = 1'b0;
      m_err    = 1'b0;
      m_mode   = 1'b0;
      m_n      = 0;
      m_since  = 0;
      m_hr     = 0;
      m_sec    = 0;
    end else begin
      m_err = 1'b0;
      if (m_load) begin
        if (lif.load_ready) m_load = 1'b0;
      end else if (cancel) begin
        m_active = 1'b0;
      end else if (start) begin
        m_active = 1'b1;
        m_n      = 0;
        m_mode   = mode;
        m_since  = 0;
      end else if (m_active) begin
        if (digit_valid && acceptable(m_n, int'(digit), m_mode, m_dig[0], m_dig[2])) begin
          m_dig[m_n] = int'(digit);
          m_since    = 0;
          if (m_n == 3) begin
            m_hr = m_dig[0] * 10 + m_dig[1];
            if (!m_mode) m_hr = (m_hr % 12) + (pm ? 12 : 0);
            m_sec    = m_dig[2] * 10 + m_dig[3];
            m_load   = 1'b1;
            m_active = 1'b0;
            m_n      = 0;
          end else begin
            m_n++;
          end
        end else begin
          m_since++;
          if (m_since >= T) begin
            m_active = 1'b0;
            m_err    = 1'b1;
          end else if (digit_valid) begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, m_active);
      check("digit_pos", digit_pos, m_active ? m_n : 0);
      check("err", err, m_err);
      check("load_valid", lif.load_valid, m_load);
      if (m_load) begin
        check("hr_bin", lif.hr_bin, m_hr);
        check("sec_bin", lif.sec_bin, m_sec);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic dig(input int d);
    digit_valid = 1'b1;
    digit       = 4'(d);
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic begin_entry(input bit md);
    start = 1'b1;
    mode  = md;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic to_idle();
    cancel         = 1'b1;
    lif.load_ready = 1'b1;
    @(negedge clk);
    cancel         = 1'b0;
    lif.load_ready = 1'b0;
  endtask

  initial begin
    lif.load_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_load_valid", lif.load_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_digit_pos", digit_pos, 0);
    check("rst_err", err, 0);
    check("rst_hr_bin", lif.hr_bin, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    tick();

    // 24h 23:59, then held off by load_ready with start pulses.
    begin_entry(1'b1);
    dig(2); dig(3); dig(5); dig(9);
    check("t24_valid", lif.load_valid, 1);
    check("t24_hr", lif.hr_bin, 23);
    check("t24_sec", lif.sec_bin, 59);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    check("hold_valid", lif.load_valid, 1);
    check("hold_hr", lif.hr_bin, 23);
    check("hold_busy", busy, 0);
    lif.load_ready = 1'b1;
    tick();
    lif.load_ready = 1'b0;
    check("handshake_done", lif.load_valid, 0);

    begin_entry(1'b0);
    pm = 1'b0;
    dig(1); dig(2); dig(0); dig(0);
    check("t12_am12_hr", lif.hr_bin, 0);
    to_idle();
    begin_entry(1'b0);
    dig(1); dig(2); dig(0);
    pm = 1'b1;
    dig(0);
    check("t12_pm12_hr", lif.hr_bin, 12);
    to_idle();
    begin_entry(1'b0);
    dig(0); dig(7); dig(3); dig(0);
    check("t12_pm7_hr", lif.hr_bin, 19);
    check("t12_pm7_sec", lif.sec_bin, 30);
    to_idle();
    pm = 1'b0;

    begin_entry(1'b1);
    dig(2); dig(4);
    check("rej24_err", err, 1);
    check("rej24_pos", digit_pos, 1);
    tick();
    check("rej24_err_clear", err, 0);
    dig(3);
    check("rej24_then_ok", digit_pos, 2);
    to_idle();
    begin_entry(1'b0);
    dig(0); dig(0);
    check("rej12_00_err", err, 1);
    check("rej12_00_pos", digit_pos, 1);
    to_idle();
    begin_entry(1'b0);
    dig(6);
    check("rej12_6_err", err, 1);
    check("rej12_6_pos", digit_pos, 0);
    to_idle();

    begin_entry(1'b1);
    dig(1);
    repeat (T - 1) tick();
    check("tmo_still_busy", busy, 1);
    tick();
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_no_load", lif.load_valid, 0);
    tick();

    begin_entry(1'b1);
    dig(2);
    cancel      = 1'b1;
    digit_valid = 1'b1;
    digit       = 4'd3;
    tick();
    cancel      = 1'b0;
    digit_valid = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_err", err, 0);
    check("cancel_pos", digit_pos, 0);

    begin_entry(1'b1);
    dig(2); dig(3);
    check("mid_pos", digit_pos, 2);
    begin_entry(1'b1);
    check("restart_pos", digit_pos, 0);
    check("restart_busy", busy, 1);
    to_idle();

    begin_entry(1'b1);
    dig(1); dig(2); dig(3); dig(4);
    check("pre_rst_valid", lif.load_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", lif.load_valid, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        digit_valid = 1'b0;
        start       = 1'b0;
        cancel      = 1'b0;
        repeat (T + 4) tick();
      end
      start          = ($urandom_range(0, 39) == 0);
      cancel         = ($urandom_range(0, 59) == 0);
      mode           = $urandom_range(0, 1) != 0;
      pm             = $urandom_range(0, 1) != 0;
      lif.load_ready = $urandom_range(0, 1) != 0;
      digit_valid    = $urandom_range(0, 1) != 0;
      digit          = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      tick();
    end
    start       = 1'b0;
    cancel      = 1'b0;
    digit_valid = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
